// File: rtl/vip_cmos_timing_gen_if.sv
// rtl/vip_cmos_timing_gen_if.sv - frame-memory read port and timed pixel output stream
interface vip_cmos_timing_gen_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 11
);
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic              post_frame_vsync;
  logic              post_frame_href;
  logic              post_frame_clken;
  logic [DATA_W-1:0] post_img_data;
  logic [CNT_W-1:0]  post_x;
  logic [CNT_W-1:0]  post_y;

  modport master (
    output o_rd_en, o_rd_addr,
    input  i_rd_data,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_img_data, post_x, post_y
  );

  modport slave (
    input  o_rd_en, o_rd_addr,
    output i_rd_data,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_img_data, post_x, post_y
  );
endinterface

// File: rtl/vip_cmos_timing_gen.sv
// rtl/vip_cmos_timing_gen.sv - camera timing source, memory or test-pattern pixels, 2-clk pipeline
// Test patterns (modes 1-3) are built only when VIP_TPG_PATTERN_EN is defined.
module vip_cmos_timing_gen #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_SYNC    = 5,
  parameter int H_BACK    = 5,
  parameter int H_FRONT   = 5,
  parameter int V_SYNC    = 1,
  parameter int V_BACK    = 0,
  parameter int V_FRONT   = 1,
  parameter int CLKEN_DIV = 2,
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 20,
  parameter int CNT_W     = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
  input  logic [1:0]             i_mode,
  vip_cmos_timing_gen_if.master  bus,
  output logic [15:0]            o_frame_cnt,
  output logic                   o_frame_done
);
  localparam int H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int DIV_W   = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [1:0]        mode_q, mode_d, mode_in;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d, addr1_q, addr1_d;
  logic              rd_en1_q, rd_en1_d, active1_q, active1_d, tick1_q, tick1_d;
  logic              vsync1_q, vsync1_d, end1_q, end1_d, mem1_q, mem1_d;
  logic [CNT_W-1:0]  x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [DATA_W-1:0] pat_d, pat1_q, pat1_d, pat2_q, pat2_d;
  logic              href2_q, href2_d, clken2_q, clken2_d, vsync2_q, vsync2_d;
  logic              done2_q, done2_d, mem2_q, mem2_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic             run, tick, h_last, v_last, frame_end, active;
  logic [CNT_W-1:0] x0, y0;

  assign run       = (state_q == RUN);
  assign tick      = run && (div_q == DIV_W'(CLKEN_DIV - 1));
  assign h_last    = (hcnt_q == CNT_W'(H_TOTAL - 1));
  assign v_last    = (vcnt_q == CNT_W'(V_TOTAL - 1));
  assign frame_end = tick && h_last && v_last;
  assign active    = run
                  && (vcnt_q >= CNT_W'(V_START)) && (vcnt_q < CNT_W'(V_START + IMG_VDISP))
                  && (hcnt_q >= CNT_W'(H_START)) && (hcnt_q < CNT_W'(H_START + IMG_HDISP));
  assign x0        = hcnt_q - CNT_W'(H_START);
  assign y0        = vcnt_q - CNT_W'(V_START);

`ifdef VIP_TPG_PATTERN_EN
  localparam int BAR_W = (IMG_HDISP / 8 > 0) ? IMG_HDISP / 8 : 1;
  logic [2:0]  bar;
  logic [23:0] pat24;
  assign mode_in = i_mode;

  always_comb begin
    bar = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (x0 >= CNT_W'(b * BAR_W)) bar = 3'(b);
    end
    pat24 = 24'h000000;
    case (mode_q)
      2'd1: begin
        case (bar)
          3'd0:    pat24 = 24'hFFFFFF;
          3'd1:    pat24 = 24'hFFFF00;
          3'd2:    pat24 = 24'h00FFFF;
          3'd3:    pat24 = 24'h00FF00;
          3'd4:    pat24 = 24'hFF00FF;
          3'd5:    pat24 = 24'hFF0000;
          3'd6:    pat24 = 24'h0000FF;
          default: pat24 = 24'h000000;
        endcase
      end
      2'd2:    pat24 = {3{x0[7:0]}};
      2'd3:    pat24 = (x0[5] ^ y0[5]) ? 24'hFFFFFF : 24'h000000;
      default: pat24 = 24'h000000;
    endcase
    pat_d = '0;
    if (DATA_W == 24) pat_d = DATA_W'(pat24);
  end
`else
  logic unused_mode;
  assign unused_mode = ^i_mode;
  assign mode_in     = 2'd0;
  assign pat_d       = '0;
`endif

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    mode_d     = mode_q;
    addr_cnt_d = addr_cnt_q;
    case (state_q)
      IDLE: begin
        div_d      = '0;
        hcnt_d     = '0;
        vcnt_d     = '0;
        addr_cnt_d = '0;
        if (i_enable) begin
          state_d = RUN;
          mode_d  = mode_in;
        end
      end
      default: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + CNT_W'(1);
          end else begin
            hcnt_d = hcnt_q + CNT_W'(1);
          end
          if (active) addr_cnt_d = addr_cnt_q + ADDR_W'(1);
        end
        // Enable and mode are only honoured at the frame boundary.
        if (frame_end) begin
          addr_cnt_d = '0;
          if (i_enable) mode_d = mode_in;
          else          state_d = IDLE;
        end
      end
    endcase

    rd_en1_d  = active && tick && (mode_q == 2'd0);
    addr1_d   = addr_cnt_q;
    active1_d = active;
    tick1_d   = tick;
    vsync1_d  = run && (vcnt_q >= CNT_W'(V_SYNC));
    end1_d    = run && frame_end;
    mem1_d    = (mode_q == 2'd0);
    x1_d      = active ? x0 : '0;
    y1_d      = active ? y0 : '0;
    pat1_d    = pat_d;

    href2_d     = active1_q;
    clken2_d    = active1_q && tick1_q;
    vsync2_d    = vsync1_q;
    done2_d     = end1_q;
    mem2_d      = mem1_q;
    x2_d        = x1_q;
    y2_d        = y1_q;
    pat2_d      = pat1_q;
    frame_cnt_d = frame_cnt_q + 16'(end1_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      mode_q      <= '0;
      addr_cnt_q  <= '0;
      addr1_q     <= '0;
      rd_en1_q    <= 1'b0;
      active1_q   <= 1'b0;
      tick1_q     <= 1'b0;
      vsync1_q    <= 1'b0;
      end1_q      <= 1'b0;
      mem1_q      <= 1'b0;
      x1_q        <= '0;
      y1_q        <= '0;
      pat1_q      <= '0;
      href2_q     <= 1'b0;
      clken2_q    <= 1'b0;
      vsync2_q    <= 1'b0;
      done2_q     <= 1'b0;
      mem2_q      <= 1'b0;
      x2_q        <= '0;
      y2_q        <= '0;
      pat2_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      mode_q      <= mode_d;
      addr_cnt_q  <= addr_cnt_d;
      addr1_q     <= addr1_d;
      rd_en1_q    <= rd_en1_d;
      active1_q   <= active1_d;
      tick1_q     <= tick1_d;
      vsync1_q    <= vsync1_d;
      end1_q      <= end1_d;
      mem1_q      <= mem1_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      pat1_q      <= pat1_d;
      href2_q     <= href2_d;
      clken2_q    <= clken2_d;
      vsync2_q    <= vsync2_d;
      done2_q     <= done2_d;
      mem2_q      <= mem2_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      pat2_q      <= pat2_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Memory data arrives during the Stage2 cycle, so it is muxed in rather than re-registered.
  assign bus.o_rd_en          = rd_en1_q;
  assign bus.o_rd_addr        = addr1_q;
  assign bus.post_frame_vsync = vsync2_q;
  assign bus.post_frame_href  = href2_q;
  assign bus.post_frame_clken = clken2_q;
  assign bus.post_img_data    = !clken2_q ? '0 : (mem2_q ? bus.i_rd_data : pat2_q);
  assign bus.post_x           = x2_q;
  assign bus.post_y           = y2_q;
  assign o_frame_cnt          = frame_cnt_q;
  assign o_frame_done         = done2_q;
endmodule

// File: tb/tb_vip_cmos_timing_gen.sv
// tb/tb_vip_cmos_timing_gen.sv - directed bench for vip_cmos_timing_gen (DIV=2 and DIV=1 instances)
module tb_vip_cmos_timing_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0, en1 = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] fcnt, fcnt1;
  logic        done, done1;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  vip_cmos_timing_gen_if #(.DATA_W(24), .ADDR_W(20), .CNT_W(11)) bus ();
  vip_cmos_timing_gen_if #(.DATA_W(24), .ADDR_W(20), .CNT_W(11)) bus1 ();

  vip_cmos_timing_gen #(.IMG_HDISP(8), .IMG_VDISP(4), .H_SYNC(2), .H_BACK(2), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .CLKEN_DIV(2), .DATA_W(24), .ADDR_W(20), .CNT_W(11))
  dut (.clk(clk), .rst_n(rst_n), .i_enable(en), .i_mode(mode), .bus(bus),
       .o_frame_cnt(fcnt), .o_frame_done(done));

  vip_cmos_timing_gen #(.IMG_HDISP(8), .IMG_VDISP(4), .H_SYNC(2), .H_BACK(2), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .CLKEN_DIV(1), .DATA_W(24), .ADDR_W(20), .CNT_W(11))
  dut1 (.clk(clk), .rst_n(rst_n), .i_enable(en1), .i_mode(2'd0), .bus(bus1),
        .o_frame_cnt(fcnt1), .o_frame_done(done1));

  initial begin
    bus.i_rd_data  = '0;
    bus1.i_rd_data = '0;
  end
  always @(posedge clk) if (bus.o_rd_en)  bus.i_rd_data  <= 24'(bus.o_rd_addr);
  always @(posedge clk) if (bus1.o_rd_en) bus1.i_rd_data <= 24'(bus1.o_rd_addr);

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int          w_len, w_clken, w_href, w_lines, w_vlow;
  bit          w_timeout;
  logic [23:0] d_q[$];
  int          x_q[$], y_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int m, input int k);
    logic [10:0] xv, yv;
    xv = 11'(k % 8);
    yv = 11'(k / 8);
`ifdef VIP_TPG_PATTERN_EN
    if (m == 1) return bars[k % 8];
    if (m == 2) return {3{xv[7:0]}};
    if (m == 3) return (xv[5] ^ yv[5]) ? 24'hFFFFFF : 24'h000000;
`endif
    return 24'(k);
  endfunction

  // Samples one frame window up to and including the o_frame_done cycle.
  task automatic collect(input int act_cyc, input logic [1:0] act_mode, input logic act_en);
    logic href_prev;
    href_prev = 1'b0;
    w_len = 0; w_clken = 0; w_href = 0; w_lines = 0; w_vlow = 0; w_timeout = 1'b1;
    d_q.delete(); x_q.delete(); y_q.delete();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == act_cyc) begin
        mode = act_mode;
        en   = act_en;
      end
      w_len++;
      if (bus.post_frame_href) w_href++;
      if (bus.post_frame_href && !href_prev) w_lines++;
      href_prev = bus.post_frame_href;
      if (!bus.post_frame_vsync) w_vlow++;
      if (bus.post_frame_clken) begin
        w_clken++;
        d_q.push_back(bus.post_img_data);
        x_q.push_back(int'(bus.post_x));
        y_q.push_back(int'(bus.post_y));
      end
      if (done) begin
        w_timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_data(input string tag, input int m);
    for (int k = 0; k < 32; k++) begin
      if (k < d_q.size()) chk($sformatf("%s_px%0d", tag, k), 32'(d_q[k]), 32'(exp_pix(m, k)));
    end
  endtask

  initial begin
    int mism, dcnt, per, h1, vl1, cnt_done, cnt_href, guard;
    logic [1:0] m2, m3;
`ifdef VIP_TPG_PATTERN_EN
    m2 = 2'd1; m3 = 2'd3;
`else
    m2 = 2'd0; m3 = 2'd0;
`endif
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vsync", 32'(bus.post_frame_vsync), 0);
    chk("rst_href",  32'(bus.post_frame_href), 0);
    chk("rst_clken", 32'(bus.post_frame_clken), 0);
    chk("rst_data",  32'(bus.post_img_data), 0);
    chk("rst_rd_en", 32'(bus.o_rd_en), 0);
    chk("rst_addr",  32'(bus.o_rd_addr), 0);
    chk("rst_fcnt",  32'(fcnt), 0);
    chk("rst_done",  32'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: memory mode; mode=1 requested mid-frame takes effect from frame 2.
    mode = 2'd0;
    en   = 1'b1;
    collect(20, 2'd1, 1'b1);
    chk("f1_timeout", 32'(w_timeout), 0);
    chk("f1_latency", 32'(w_len), 198);
    chk("f1_clken",   32'(w_clken), 32);
    chk("f1_href",    32'(w_href), 64);
    chk("f1_lines",   32'(w_lines), 4);
    chk("f1_fcnt",    32'(fcnt), 1);
    check_data("f1", 0);
    for (int k = 0; k < 32; k += 9) begin
      if (k < x_q.size()) begin
        chk($sformatf("f1_x%0d", k), 32'(x_q[k]), 32'(k % 8));
        chk($sformatf("f1_y%0d", k), 32'(y_q[k]), 32'(k / 8));
      end
    end

    // Frame 2: bars; switch to checkerboard mid-frame.
    collect(100, 2'd3, 1'b1);
    chk("f2_timeout", 32'(w_timeout), 0);
    chk("f2_period",  32'(w_len), 196);
    chk("f2_vlow",    32'(w_vlow), 28);
    chk("f2_clken",   32'(w_clken), 32);
    chk("f2_href",    32'(w_href), 64);
    chk("f2_fcnt",    32'(fcnt), 2);
    check_data("f2", int'(m2));

    // Frame 3: checkerboard; enable dropped during line 2.
    collect(70, 2'd3, 1'b0);
    chk("f3_timeout", 32'(w_timeout), 0);
    chk("f3_period",  32'(w_len), 196);
    chk("f3_clken",   32'(w_clken), 32);
    chk("f3_fcnt",    32'(fcnt), 3);
    check_data("f3", int'(m3));
    repeat (5) @(negedge clk);
    chk("idle_vsync", 32'(bus.post_frame_vsync), 0);
    chk("idle_href",  32'(bus.post_frame_href), 0);
    chk("idle_clken", 32'(bus.post_frame_clken), 0);
    chk("idle_data",  32'(bus.post_img_data), 0);
    chk("idle_rd_en", 32'(bus.o_rd_en), 0);
    cnt_done = 0; cnt_href = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (bus.post_frame_href) cnt_href++;
    end
    chk("idle_no_done", 32'(cnt_done), 0);
    chk("idle_no_href", 32'(cnt_href), 0);
    chk("idle_fcnt",    32'(fcnt), 3);

    // CLKEN_DIV=1 instance.
    en1 = 1'b1;
    mism = 0; dcnt = 0; per = 0; h1 = 0; vl1 = 0;
    for (int c = 0; c < 400 && dcnt < 2; c++) begin
      @(negedge clk);
      if (bus1.post_frame_clken !== bus1.post_frame_href) mism++;
      if (dcnt == 1) begin
        per++;
        if (bus1.post_frame_href) h1++;
        if (!bus1.post_frame_vsync) vl1++;
      end
      if (done1) dcnt++;
    end
    en1 = 1'b0;
    chk("d1_dones",    32'(dcnt), 2);
    chk("d1_clk_href", 32'(mism), 0);
    chk("d1_period",   32'(per), 98);
    chk("d1_href",     32'(h1), 32);
    chk("d1_vlow",     32'(vl1), 14);
    chk("d1_fcnt",     32'(fcnt1), 2);

    // Asynchronous reset in the middle of a line.
    mode = 2'd0;
    en   = 1'b1;
    guard = 0;
    while (!bus.post_frame_href && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("r_href_seen", 32'(bus.post_frame_href), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_vsync", 32'(bus.post_frame_vsync), 0);
    chk("r_href",  32'(bus.post_frame_href), 0);
    chk("r_clken", 32'(bus.post_frame_clken), 0);
    chk("r_data",  32'(bus.post_img_data), 0);
    chk("r_fcnt",  32'(fcnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    while (!bus.o_rd_en && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("r_rd_en_seen", 32'(bus.o_rd_en), 1);
    chk("r_first_addr", 32'(bus.o_rd_addr), 0);
    en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
